// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared types for the multi-cycle adder/subtractor.
//   state_e : controller states (IDLE, RUN, DONE)
//   flags_t : condition flags {n, z, c, v}
//   idx_width() : width of a chunk index able to count 0..n-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// -----------------------------------------------------------------------------
// full_adder / chunk_adder
// full_adder : one-bit full adder cell.
//   a, b, cin -> s (sum), cout (carry out)
// chunk_adder: CHUNK-bit ripple of full_adder cells.
//   a, b  [CHUNK-1:0] : operand slices
//   cin               : carry into bit 0
//   s     [CHUNK-1:0] : sum slice
//   cout              : carry out of the top bit
//   c_msb             : carry into the top bit (used for signed overflow)
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule

module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  // w_c[i] is the carry into bit i; w_c[CHUNK] is the carry out of the slice.
  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_c[i]),
      .s    (s[i]),
      .cout (w_c[i+1])
    );
  end

  assign cout  = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/multi_cycle_adder.sv
// -----------------------------------------------------------------------------
// multi_cycle_adder
// WIDTH-bit adder/subtractor that works CHUNK bits per clock, keeping the
// carry in a register between chunks. Produces N/Z/C/V flags.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high on that side; valid, once raised, is held until that edge, and the data
// it qualifies stays stable meanwhile. Only one operation is in flight.
//
// Ports:
//   clk, rst_n               : clock (rising edge), async active-low reset
//   in_valid / in_ready      : operand handshake
//   a, b [WIDTH-1:0]         : operands
//   cin                      : carry-in (add) / borrow-in (subtract)
//   sub                      : 0 -> a+b+cin, 1 -> a-b-cin
//   out_valid / out_ready    : result handshake
//   result [WIDTH-1:0]       : sum or difference
//   flag_n/z/c/v             : negative, zero, carry (no-borrow), overflow
//   o_dbg_state              : current controller state
// -----------------------------------------------------------------------------
module multi_cycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output state_e           o_dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("multi_cycle_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;        // already inverted for subtract
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic             r_zacc;     // running "all chunks so far are zero"
  logic [WIDTH-1:0] r_result;
  flags_t           r_flags;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_c_msb;
  logic             w_last;
  logic             w_zchunk;

  // Select the operand slices for the current chunk index.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_a_chunk = r_a[k*CHUNK +: CHUNK];
        w_b_chunk = r_b[k*CHUNK +: CHUNK];
      end
    end
  end

  assign w_last   = (r_idx == IDXW'(NCHUNK - 1));
  assign w_zchunk = ~|w_sum;

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a     (w_a_chunk),
    .b     (w_b_chunk),
    .cin   (r_carry),
    .s     (w_sum),
    .cout  (w_cout),
    .c_msb (w_c_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_zacc      <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            // Subtraction is a + ~b + ~cin: invert once at accept time.
            r_b        <= sub ? ~b : b;
            r_carry    <= cin ^ sub;
            r_idx      <= '0;
            r_zacc     <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end

        RUN: begin
          for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDXW'(k)) begin
              r_result[k*CHUNK +: CHUNK] <= w_sum;
            end
          end
          r_carry <= w_cout;
          r_zacc  <= r_zacc & w_zchunk;
          if (w_last) begin
            // The top chunk holds the MSB, so all flags come from this cycle.
            r_flags.n   <= w_sum[CHUNK-1];
            r_flags.z   <= r_zacc & w_zchunk;
            r_flags.c   <= w_cout;
            r_flags.v   <= w_cout ^ w_c_msb;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign flag_n      = r_flags.n;
  assign flag_z      = r_flags.z;
  assign flag_c      = r_flags.c;
  assign flag_v      = r_flags.v;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multi_cycle_adder.sv
module tb_multi_cycle_adder;
  import adder_pkg::*;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  // ---------------------------------------------------------------- signals
  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             sub_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_n, flag_z, flag_c, flag_v;
  state_e           dbg_state;

  int      n_checks = 0;
  int      n_fail   = 0;
  longint  cyc      = 0;
  bit      rand_bp  = 0;

  // Expected {result, n, z, c, v}
  logic [WIDTH+3:0] exp_q[$];

  multi_cycle_adder #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a_in),
    .b           (b_in),
    .cin         (cin_in),
    .sub         (sub_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .flag_n      (flag_n),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .flag_v      (flag_v),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ------------------------------------------------------------ reference
  // Plain integer arithmetic on 64-bit values: unsigned for result/carry,
  // signed for overflow.
  function automatic logic [WIDTH+3:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                             input logic mcin, input logic msub);
    longint ua, ub, sa, sb, ci, ur, sr;
    logic [31:0] res;
    logic c, v;
    ua = 0; ua[31:0] = ma;
    ub = 0; ub[31:0] = mb;
    sa = $signed(ma);
    sb = $signed(mb);
    ci = mcin ? 1 : 0;
    if (!msub) begin
      ur = ua + ub + ci;
      sr = sa + sb + ci;
      c  = (ur > 64'sd4294967295);
    end else begin
      ur = ua - ub - ci;
      sr = sa - sb - ci;
      c  = (ua >= ub + ci);
    end
    v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    res = ur[31:0];
    return {res, res[31], (res == 32'd0), c, v};
  endfunction

  // ------------------------------------------------------------- checking
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: condition not reached within bound (t=%0t)", name, $time);
  endtask

  // Monitor: pops the scoreboard on each output transfer, checks latency,
  // hold stability during backpressure, and in_ready low while a result waits.
  logic             mon_prev_ov = 1'b0;
  logic [WIDTH+3:0] mon_held;
  longint           mon_acc_edge = -1;

  always @(negedge clk) begin
    logic [WIDTH+3:0] got;
    logic [WIDTH+3:0] exp;
    got = {result, flag_n, flag_z, flag_c, flag_v};
    if (!rst_n) begin
      mon_prev_ov  = 1'b0;
      mon_acc_edge = -1;
    end else begin
      if (out_valid && !mon_prev_ov) begin
        if (mon_acc_edge >= 0) check("latency", 64'(cyc - mon_acc_edge), 64'(NCHUNK));
        mon_held = got;
      end
      if (out_valid && mon_prev_ov) check("done_hold", 64'(got), 64'(mon_held));
      if (out_valid) check("in_ready_in_done", 64'(in_ready), 64'd0);
      if (in_valid && in_ready) mon_acc_edge = cyc + 1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          check("result", 64'(got[WIDTH+3:4]), 64'(exp[WIDTH+3:4]));
          check("flags_nzcv", 64'(got[3:0]), 64'(exp[3:0]));
        end
      end
      mon_prev_ov = out_valid;
    end
  end

  // --------------------------------------------------------------- driver
  // Called away from the clock edge; returns #1 after the accept edge.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v, input logic tcin,
                       input logic tsub, input bit keep, output longint acc);
    int guard;
    a_in     = ta;
    b_in     = tb_v;
    cin_in   = tcin;
    sub_in   = tsub;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    exp_q.push_back(model(ta, tb_v, tcin, tsub));
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || !in_ready) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0 || !in_ready) fail_now("drain");
  endtask

  task automatic wait_out_valid();
    int guard;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!out_valid) fail_now("out_valid_timeout");
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    longint acc0, acc1, acc2, acc;
    logic [31:0] corners [6];
    logic [31:0] ra, rb;
    corners = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    cin_in    = 1'b0;
    sub_in    = 1'b0;
    out_ready = 1'b1;

    #12;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", 64'({flag_n, flag_z, flag_c, flag_v}), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed add / subtract cases
    issue(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0, acc); drain();
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, acc); drain();
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, acc); drain();
    issue(32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0, acc); drain();
    issue(32'h00000007, 32'h00000005, 1'b1, 1'b1, 1'b0, acc); drain();
    issue(32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0, acc); drain();
    issue(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, acc); drain();

    // Backpressure in DONE with inputs toggling
    out_ready = 1'b0;
    issue(32'h0000AAAA, 32'h00005555, 1'b0, 1'b0, 1'b0, acc);
    wait_out_valid();
    for (int i = 0; i < 3; i++) begin
      a_in     = $urandom();
      b_in     = $urandom();
      in_valid = ~in_valid;
      @(posedge clk); #1;
      check("bp_state_done", 64'(dbg_state), 64'(DONE));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_state", 64'(dbg_state), 64'(IDLE));
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    issue(32'h01020304, 32'h10203040, 1'b0, 1'b0, 1'b1, acc0);
    issue(32'hDEADBEEF, 32'h12345678, 1'b1, 1'b1, 1'b1, acc1);
    issue(32'h0000FFFF, 32'hFFFF0001, 1'b0, 1'b0, 1'b0, acc2);
    check("b2b_spacing_1", 64'(acc1 - acc0), 64'(NCHUNK + 2));
    check("b2b_spacing_2", 64'(acc2 - acc1), 64'(NCHUNK + 2));
    drain();

    // Reset mid-RUN after the second chunk
    issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0, acc);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_out_valid", 64'(out_valid), 64'd0);
    check("midrun_result", 64'(result), 64'd0);
    check("midrun_in_ready", 64'(in_ready), 64'd1);
    check("midrun_state", 64'(dbg_state), 64'(IDLE));
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue(32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0, acc); drain();

    // Randomized operations with random output backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
      issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, acc);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        @(posedge clk); #1;
      end
    end
    rand_bp = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
